// File: rtl/boot_selector.sv
// -----------------------------------------------------------------------------
// boot_selector
//
// Boot-image selection controller for the iCE40 stub bootloader. A released
// button at power-up boots DEFAULT_IMAGE. A held button enters select mode:
// each press advances the image (modulo N_IMAGES), and a period of released
// button commits the choice. The commit optionally requests a flash-lock
// handshake (fl_go / fl_rdy) and then raises a registered boot strobe for
// SB_WARMBOOT.
//
// Optional feature macro: BOOT_SEL_LONGPRESS_EN
//   When defined, holding the button for 2^LONG_LOG2 cycles in select mode
//   commits the current selection immediately.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   btn_v      in   filtered button level, 1 = released
//   btn_f      in   one-cycle press strobe
//   fl_rdy     in   flash lock done (tie high when no lock is used)
//   fl_go      out  one-cycle flash-lock request (combinational)
//   boot_sel   out  selected image, S1:S0 of SB_WARMBOOT (registered)
//   boot_now   out  boot strobe to SB_WARMBOOT.BOOT (registered)
//   boot_pend  out  high while in BOOT (combinational LED override)
//   sel_mode   out  high in SEL or SEL_WAIT
//   skip_lock  out  sticky lock-bypass request (registered)
// -----------------------------------------------------------------------------
module boot_selector #(
    parameter int N_IMAGES      = 4,
    parameter int DEFAULT_IMAGE = 2,
    parameter int SEL_IMAGE     = 1,
    parameter int TIMEOUT_LOG2  = 23,
    parameter int REARM_LOG2    = 17,
    parameter int LONG_LOG2     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_v,
    input  logic       btn_f,
    input  logic       fl_rdy,
    output logic       fl_go,
    output logic [1:0] boot_sel,
    output logic       boot_now,
    output logic       boot_pend,
    output logic       sel_mode,
    output logic       skip_lock
);

    localparam int TW = TIMEOUT_LOG2 + 1;

    // Reject parameter sets the selection and timer logic cannot represent.
    if (N_IMAGES < 2 || N_IMAGES > 4 || LONG_LOG2 < 1 ||
        REARM_LOG2 >= TIMEOUT_LOG2) begin : g_param_check
        $error("boot_selector: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_WAIT_REL = 3'd1,
        ST_SEL      = 3'd2,
        ST_SEL_WAIT = 3'd3,
        ST_LOCK     = 3'd4,
        ST_BOOT     = 3'd5
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    state_t          commit_state_s;
    logic [TW-1:0]   timer_r;
    logic            tick_s;
    logic            long_hit_s;
    logic [1:0]      sel_inc_s;

`ifdef BOOT_SEL_LONGPRESS_EN
    localparam int LW = LONG_LOG2 + 1;
    logic [LW-1:0]   long_r;

    // Hold-length counter: runs only while the button is held in select mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_r <= '0;
        end else if (btn_v) begin
            long_r <= '0;
        end else if (state_r == ST_SEL || state_r == ST_SEL_WAIT) begin
            long_r <= long_r + LW'(1);
        end else begin
            long_r <= '0;
        end
    end

    assign long_hit_s = long_r[LONG_LOG2];
`else
    assign long_hit_s = 1'b0;
`endif

    // Re-arm uses the short timer bit, every other state the commit timeout.
    assign tick_s = (state_r == ST_SEL_WAIT) ? timer_r[REARM_LOG2]
                                             : timer_r[TIMEOUT_LOG2];

    // A bypassed lock goes straight to BOOT on commit.
    assign commit_state_s = skip_lock ? ST_BOOT : ST_LOCK;

    // Selection increment with wrap at N_IMAGES.
    assign sel_inc_s = (boot_sel == 2'(N_IMAGES - 1)) ? 2'd0 : boot_sel + 2'd1;

    // Next-state decode; reset forces START so fl_go stays low during reset.
    always_comb begin
        next_state_s = state_r;
        if (rst) begin
            next_state_s = ST_START;
        end else begin
            case (state_r)
                ST_START: begin
                    if (btn_v) begin
                        next_state_s = ST_LOCK;
                    end else begin
                        next_state_s = ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (btn_v) begin
                        next_state_s = ST_SEL_WAIT;
                    end else begin
                        next_state_s = ST_WAIT_REL;
                    end
                end
                ST_SEL: begin
                    // A press beats both the long-press and timeout commits.
                    if (btn_f) begin
                        next_state_s = ST_SEL_WAIT;
                    end else if (long_hit_s || tick_s) begin
                        next_state_s = commit_state_s;
                    end else begin
                        next_state_s = ST_SEL;
                    end
                end
                ST_SEL_WAIT: begin
                    if (long_hit_s) begin
                        next_state_s = commit_state_s;
                    end else if (tick_s) begin
                        next_state_s = ST_SEL;
                    end else begin
                        next_state_s = ST_SEL_WAIT;
                    end
                end
                ST_LOCK: begin
                    if (fl_rdy) begin
                        next_state_s = ST_BOOT;
                    end else begin
                        next_state_s = ST_LOCK;
                    end
                end
                ST_BOOT: begin
                    next_state_s = ST_BOOT;
                end
                default: begin
                    next_state_s = ST_START;
                end
            endcase
        end
    end

    // Controller state, timer, selection and sticky/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_START;
            timer_r   <= '0;
            boot_sel  <= 2'(DEFAULT_IMAGE);
            skip_lock <= 1'b0;
            boot_now  <= 1'b0;
        end else begin
            state_r <= next_state_s;

            // The timer only measures continuous released-button time.
            if (!btn_v || tick_s) begin
                timer_r <= '0;
            end else begin
                timer_r <= timer_r + TW'(1);
            end

            if (state_r == ST_WAIT_REL) begin
                boot_sel <= 2'(SEL_IMAGE);
            end else if (state_r == ST_SEL && btn_f) begin
                boot_sel <= sel_inc_s;
            end else begin
                boot_sel <= boot_sel;
            end

            // Pressing while image 0 is shown requests the lock bypass.
            if (state_r == ST_SEL && btn_f && boot_sel == 2'd0) begin
                skip_lock <= 1'b1;
            end else begin
                skip_lock <= skip_lock;
            end

            boot_now <= boot_pend;
        end
    end

    assign fl_go     = (state_r != ST_LOCK) && (next_state_s == ST_LOCK);
    assign boot_pend = (state_r == ST_BOOT);
    assign sel_mode  = (state_r == ST_SEL) || (state_r == ST_SEL_WAIT);

endmodule

// File: tb/tb_boot_selector.sv
// -----------------------------------------------------------------------------
// tb_boot_selector
//
// Scoreboard bench for boot_selector (N_IMAGES=3, TIMEOUT_LOG2=6,
// REARM_LOG2=3, LONG_LOG2=5). Stimulus pushes the expected fl_go pulses and
// boot_now rising edges (kind, cycle, selection, skip flag) into a queue; a
// monitor on the falling clock edge pops and compares each one as it appears.
// Cycle numbers are hand-derived from the released-button timing.
// -----------------------------------------------------------------------------
module tb_boot_selector;

    localparam int K_FLGO = 1;
    localparam int K_BOOT = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] sel;
        logic       skip;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_v;
    logic       btn_f;
    logic       fl_rdy;
    logic       fl_go;
    logic [1:0] boot_sel;
    logic       boot_now;
    logic       boot_pend;
    logic       sel_mode;
    logic       skip_lock;

    int   cyc  = 0;
    int   ncmp = 0;
    int   nfail = 0;
    logic now_prev = 1'b0;
    exp_t q[$];

    boot_selector #(
        .N_IMAGES     (3),
        .DEFAULT_IMAGE(2),
        .SEL_IMAGE    (1),
        .TIMEOUT_LOG2 (6),
        .REARM_LOG2   (3),
        .LONG_LOG2    (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_v    (btn_v),
        .btn_f    (btn_f),
        .fl_rdy   (fl_rdy),
        .fl_go    (fl_go),
        .boot_sel (boot_sel),
        .boot_now (boot_now),
        .boot_pend(boot_pend),
        .sel_mode (sel_mode),
        .skip_lock(skip_lock)
    );

    always #5 clk = ~clk;

    // Cycle index: inside cycle k (after posedge k) cyc reads k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [1:0] sel, input logic skip);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.sel  = sel;
        e.skip = skip;
        q.push_back(e);
    endtask

    task automatic got_event(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_boot_sel", {30'd0, boot_sel}, {30'd0, e.sel});
            check("event_skip_lock", {31'd0, skip_lock}, {31'd0, e.skip});
        end
    endtask

    // Monitor: every fl_go pulse and every boot_now rising edge is an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (fl_go) got_event(K_FLGO);
            if (boot_now && !now_prev) got_event(K_BOOT);
        end
        now_prev <= boot_now;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (q.size() > 0) begin
            check("drain_timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    // Two reset edges, reset-value checks, then release; returns START cycle.
    task automatic do_reset(input logic bv, output int p0);
        rst   = 1'b1;
        btn_v = bv;
        btn_f = 1'b0;
        step();
        step();
        check("rst_boot_sel", {30'd0, boot_sel}, 32'd2);
        check("rst_boot_now", {31'd0, boot_now}, 32'd0);
        check("rst_skip_lock", {31'd0, skip_lock}, 32'd0);
        check("rst_sel_mode", {31'd0, sel_mode}, 32'd0);
        check("rst_boot_pend", {31'd0, boot_pend}, 32'd0);
        check("rst_fl_go", {31'd0, fl_go}, 32'd0);
        rst = 1'b0;
        p0  = cyc;
    endtask

    // Press strobe, button held low hold more cycles, then released.
    task automatic press(input int hold, output int rl);
        btn_f = 1'b1;
        btn_v = 1'b0;
        step();
        btn_f = 1'b0;
        repeat (hold) step();
        btn_v = 1'b1;
        rl = cyc;
    endtask

    // Held through reset, released; returns the release cycle.
    task automatic enter_select(output int qc);
        int p0;
        do_reset(1'b0, p0);
        step();
        step();
        check("wait_rel_loads_sel_image", {30'd0, boot_sel}, 32'd1);
        btn_v = 1'b1;
        qc = cyc;
    endtask

    initial begin
        int p0;
        int qc;
        int rl;
        int rl2;
        int rl3;
        int e;
        int c;

        rst    = 1'b1;
        btn_v  = 1'b1;
        btn_f  = 1'b0;
        fl_rdy = 1'b0;

        // 1: released at reset -> LOCK with default image, fl_rdy 5 cycles later.
        fl_rdy = 1'b0;
        do_reset(1'b1, p0);
        push(K_FLGO, p0, 2'd2, 1'b0);
        push(K_BOOT, p0 + 7, 2'd2, 1'b0);
        step_to(p0 + 5);
        fl_rdy = 1'b1;
        step();
        check("boot_pend_in_boot", {31'd0, boot_pend}, 32'd1);
        check("boot_now_lags_pend", {31'd0, boot_now}, 32'd0);
        drain(20);
        check("boot_now_held", {31'd0, boot_now}, 32'd1);

        // 2: held through reset, released, no presses -> image 1 after 9+65.
        enter_select(qc);
        push(K_FLGO, qc + 73, 2'd1, 1'b0);
        push(K_BOOT, qc + 76, 2'd1, 1'b0);
        step();
        check("sel_mode_in_sel_wait", {31'd0, sel_mode}, 32'd1);
        drain(100);

        // 3: three presses 1->2->0->1; press at 0 sets skip_lock, no fl_go.
        enter_select(qc);
        step_to(qc + 10);
        press(1, rl);
        check("press1_sel", {30'd0, boot_sel}, 32'd2);
        step_to(rl + 10);
        press(1, rl);
        check("press2_wrap_sel", {30'd0, boot_sel}, 32'd0);
        check("skip_lock_not_yet", {31'd0, skip_lock}, 32'd0);
        step_to(rl + 10);
        press(1, rl);
        check("press3_sel", {30'd0, boot_sel}, 32'd1);
        check("skip_lock_set", {31'd0, skip_lock}, 32'd1);
        push(K_BOOT, rl + 75, 2'd1, 1'b1);
        drain(100);

        // 4: press in SEL_WAIT ignored; press on the timeout tick increments.
        enter_select(qc);
        step_to(qc + 10);
        press(1, rl);
        step_to(rl + 3);
        btn_f = 1'b1;
        btn_v = 1'b0;
        step();
        btn_f = 1'b0;
        btn_v = 1'b1;
        rl2 = cyc;
        step();
        check("sel_wait_press_ignored", {30'd0, boot_sel}, 32'd2);
        check("sel_wait_still_sel_mode", {31'd0, sel_mode}, 32'd1);
        e = rl2 + 9;
        step_to(e + 64);
        btn_f = 1'b1;
        btn_v = 1'b0;
        step();
        btn_f = 1'b0;
        btn_v = 1'b1;
        rl3 = cyc;
        check("tick_press_increments", {30'd0, boot_sel}, 32'd0);
        check("tick_press_no_commit", {31'd0, sel_mode}, 32'd1);
        push(K_FLGO, rl3 + 73, 2'd0, 1'b0);
        push(K_BOOT, rl3 + 76, 2'd0, 1'b0);
        drain(100);

        // 6: press at image 1 held 32 cycles.
        enter_select(qc);
        step_to(qc + 10);
        c = cyc;
`ifdef BOOT_SEL_LONGPRESS_EN
        push(K_FLGO, c + 32, 2'd2, 1'b0);
        push(K_BOOT, c + 35, 2'd2, 1'b0);
`else
        push(K_FLGO, c + 105, 2'd2, 1'b0);
        push(K_BOOT, c + 108, 2'd2, 1'b0);
`endif
        press(31, rl);
        check("long_press_sel", {30'd0, boot_sel}, 32'd2);
        drain(150);

        // 5: reset while LOCK waits for fl_rdy.
        fl_rdy = 1'b0;
        do_reset(1'b1, p0);
        push(K_FLGO, p0, 2'd2, 1'b0);
        step_to(p0 + 3);
        check("in_lock_no_boot", {31'd0, boot_pend}, 32'd0);
        rst = 1'b1;
        step();
        check("lock_rst_boot_sel", {30'd0, boot_sel}, 32'd2);
        check("lock_rst_skip_lock", {31'd0, skip_lock}, 32'd0);
        check("lock_rst_boot_now", {31'd0, boot_now}, 32'd0);
        check("lock_rst_sel_mode", {31'd0, sel_mode}, 32'd0);
        rst = 1'b0;
        push(K_FLGO, cyc, 2'd2, 1'b0);
        drain(5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
